// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester, read-pointer and memory-write signals of the FIFO write side
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [PTR_WIDTH:0]            rptr_gray_sync;
  logic [NUM_REQ-1:0]            gnt;
  logic                          w_en;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [PTR_WIDTH-1:0]          b_wptr;
  logic [PTR_WIDTH:0]            wptr_gray;
  logic                          full;
  logic                          half_full;
  logic [PTR_WIDTH:0]            occupancy;
  modport master (
    output req, req_data, rptr_gray_sync,
    input  gnt, w_en, wdata, b_wptr, wptr_gray, full, half_full, occupancy
  );
  modport slave (
    input  req, req_data, rptr_gray_sync,
    output gnt, w_en, wdata, b_wptr, wptr_gray, full, half_full, occupancy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing the FIFO write port, plus write pointer and full/occupancy flags
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 8,
  parameter int MAX_BURST  = 4
) (
  input logic              wclk,
  input logic              wrst_n,
  fifo_wr_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [PTR_WIDTH:0] HALF = (PTR_WIDTH + 1)'(1) << (PTR_WIDTH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_last, w_last_nxt, w_rr_idx, w_idx, w_cand;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  w_rr_hit, w_grant, w_full_nxt;
  logic                  r_w_en, r_full, r_half;
  logic [DATA_WIDTH-1:0] r_wdata, w_data;
  logic [PTR_WIDTH-1:0]  r_b_wptr;
  logic [PTR_WIDTH:0]    r_wbin, r_wgray, r_occ, w_wbin_nxt, w_wgray_nxt, w_rbin, w_occ_nxt;

  // scan from farthest to nearest so the nearest asserted requester after r_last wins
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_idx = r_last;
    w_cand   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = IW'((int'(r_last) + i) % NUM_REQ);
      if (bus.req[w_cand]) begin
        w_rr_hit = 1'b1;
        w_rr_idx = w_cand;
      end
    end
  end

  // in BURST the owner is always r_last, so one pointer serves both roles
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_grant     = 1'b0;
    w_idx       = r_last;
    if (wrst_n && !r_full) begin
      if (r_state == BURST && bus.req[r_last] && r_cnt < CW'(MAX_BURST)) begin
        w_grant   = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
      end else if (w_rr_hit) begin
        w_grant     = 1'b1;
        w_idx       = w_rr_idx;
        w_last_nxt  = w_rr_idx;
        w_cnt_nxt   = CW'(1);
        w_state_nxt = BURST;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_idx == IW'(i)) w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_rbin = '0;
    for (int i = 0; i <= PTR_WIDTH; i++) w_rbin[i] = ^(bus.rptr_gray_sync >> i);
  end

  assign w_wbin_nxt  = r_wbin + (PTR_WIDTH + 1)'(w_grant);
  assign w_wgray_nxt = w_wbin_nxt ^ (w_wbin_nxt >> 1);
  assign w_occ_nxt   = w_wbin_nxt - w_rbin;
  assign w_full_nxt  = w_wgray_nxt == {~bus.rptr_gray_sync[PTR_WIDTH -: 2], bus.rptr_gray_sync[PTR_WIDTH-2:0]};

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state <= IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_w_en   <= 1'b0;
      r_wdata  <= '0;
      r_b_wptr <= '0;
      r_wbin   <= '0;
      r_wgray  <= '0;
      r_full   <= 1'b0;
      r_half   <= 1'b0;
      r_occ    <= '0;
    end else begin
      r_w_en <= w_grant;
      if (w_grant) begin
        r_wdata  <= w_data;
        r_b_wptr <= r_wbin[PTR_WIDTH-1:0];
      end
      r_wbin  <= w_wbin_nxt;
      r_wgray <= w_wgray_nxt;
      r_full  <= w_full_nxt;
      r_half  <= w_occ_nxt >= HALF;
      r_occ   <= w_occ_nxt;
    end
  end

  assign bus.gnt       = w_grant ? NUM_REQ'(1) << w_idx : '0;
  assign bus.w_en      = r_w_en;
  assign bus.wdata     = r_wdata;
  assign bus.b_wptr    = r_b_wptr;
  assign bus.wptr_gray = r_wgray;
  assign bus.full      = r_full;
  assign bus.half_full = r_half;
  assign bus.occupancy = r_occ;
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side controller for the async FIFO. It shares the single FIFO write port among NUM_REQ requesters using round-robin arbitration with bounded burst ownership. It owns the write pointer (binary address for the memory, Gray pointer for the read-domain synchronizer) and generates full, half_full and occupancy from the already-synchronized read pointer. It sits entirely in the wclk domain, between the producers and the FIFO memory.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, data word width
- PTR_WIDTH, 8, address bits; depth = 2^PTR_WIDTH; internal pointers are PTR_WIDTH+1 bits (MSB = wrap bit); minimum 2
- MAX_BURST, 4, maximum consecutive grants to one owner (>=1)

- wclk  in  1  write-domain clock
- wrst_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester write request; held with data until granted
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
- rptr_gray_sync  in  PTR_WIDTH+1  read pointer (Gray), already synchronized into wclk
- gnt  out  NUM_REQ  one-hot, combinational; gnt[i]=1 means req_data[i] is consumed at this edge
- w_en  out  1  registered memory write enable
- wdata  out  DATA_WIDTH  registered write data
- b_wptr  out  PTR_WIDTH  registered memory write address, valid with w_en
- wptr_gray  out  PTR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer
- full  out  1  registered full flag
- half_full  out  1  registered, occupancy >= 2^(PTR_WIDTH-1)
- occupancy  out  PTR_WIDTH+1  registered word count, 0..2^PTR_WIDTH

## Operation
- State: IDLE (no owner) / BURST (owner index, burst count 1..MAX_BURST); plus rr_last (last granted index), wbin (PTR_WIDTH+1 bits).
- Grant (combinational from req, state, rr_last, registered full; no path from rptr_gray_sync):
  - full=1: gnt=0; state, count, rr_last unchanged.
  - IDLE: first asserted req searching rr_last+1, rr_last+2, … wrapping; none -> gnt=0.
  - BURST, req[owner]=1, count<MAX_BURST: gnt[owner]=1, count+1.
  - BURST, count==MAX_BURST: round-robin from owner+1; owner wins only if no other req asserted (starts new burst, count=1).
  - BURST, req[owner]=0: round-robin from owner+1 same cycle; none -> IDLE.
- Any grant to new index j: state BURST, owner=j, count=1, rr_last=j. MAX_BURST=1 degenerates to pure round-robin.
- On grant edge: w_en<=1, wdata<=req_data[j], b_wptr<=wbin[PTR_WIDTH-1:0], wbin<=wbin+1 (wraps modulo 2^(PTR_WIDTH+1)), wptr_gray<=next^(next>>1). No grant: w_en<=0; wdata, b_wptr hold.
- full<= (gray(wbin_next) == {~rptr_gray_sync[P:P-1], rptr_gray_sync[P-2:0]}), P=PTR_WIDTH, wbin_next = post-update pointer.
- occupancy<= wbin_next - gray2bin(rptr_gray_sync), modulo 2^(PTR_WIDTH+1); half_full from same value.
- Full deasserts only via read-pointer advance; stale sync pointer makes full/occupancy pessimistic, never optimistic.

## Timing
- Reset (wrst_n=0 at edge): state IDLE, rr_last=NUM_REQ-1 (first search starts at 0), wbin=0, w_en=0, wdata=0, b_wptr=0, wptr_gray=0, full=0, half_full=0, occupancy=0. gnt=0 while wrst_n=0. Reset mid-burst discards ownership and pointer.
- Latency: req accepted at edge k (gnt high in cycle before k) -> w_en/wdata/b_wptr valid cycle k..k+1 -> memory writes at edge k+1.
- Throughput: one write per cycle until full.
- Last free slot written at edge k -> full=1 from edge k; gnt=0 from cycle after.
- Requester must not change req_data while req=1 and gnt=0; may drop req only after grant.

## Test plan
- Reset, req=4'b0001, rptr_gray_sync=0, 3 cycles -> gnt=0001 each cycle, b_wptr 0,1,2, wptr_gray 1,3,2, occupancy 3.
- req=4'b1111 held, MAX_BURST=4, from reset -> grant order 0,0,0,0,1,1,1,1,2,…; w_en continuous.
- req=4'b0101, MAX_BURST=1 -> grants alternate 0,2,0,2.
- rptr_gray_sync=0, req=4'b0001 held, PTR_WIDTH=3 -> 8 writes, full=1 after 8th, gnt=0 thereafter; set rptr_gray_sync=9'b... gray(1)=4'b0001 -> full=0 next edge, one more write (b_wptr=0, wbin wraps bit 3).
- Owner drops req mid-burst (req 0001->0010) -> gnt[1] same cycle, no idle cycle.
- wrst_n=0 during burst -> all outputs 0 next edge; after release first grant goes to lowest asserted index, b_wptr=0.
